// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Outputs are decoded from the state register.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        retire,
  output logic [31:0] instret
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [2:0]  state_q, state_d;
  logic        armed_q;
  logic [31:0] instret_q;
  logic [6:0]  opcode;
  logic        is_op, is_opimm, is_load, is_store, is_branch;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_legal;
  logic        unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^inst[31:12];

  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_legal  = is_op | is_opimm | is_load | is_store | is_branch |
                     is_lui | is_auipc | is_jal | is_jalr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      // armed_q holds IDLE for one full cycle after reset release
      S_IDLE:   if (armed_q) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = is_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = S_FETCH;
        else if (is_legal)       state_d = S_WB;
        else                     state_d = S_HALT;
      end
      S_MEM:    if (mem_ready) state_d = is_store ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        if (is_op) begin
          alu_op = 2'b10;
        end else if (is_opimm) begin
          alu_src_b = 1'b1;
          alu_op    = 2'b10;
        end else if (is_load || is_store || is_lui || is_auipc) begin
          alu_src_b = 1'b1;
        end else if (is_branch) begin
          alu_op   = 2'b01;
          pc_src   = 2'd1;
          pc_write = branch_taken;
        end else if (is_jal) begin
          pc_src   = 2'd1;
          pc_write = 1'b1;
        end else if (is_jalr) begin
          alu_src_b = 1'b1;
          pc_src    = 2'd2;
          pc_write  = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
      end
      S_WB: begin
        reg_write = (inst[11:7] != 5'd0);
        if (is_load)                wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)            wb_sel = 2'd3;
        else                        wb_sel = 2'd0;
      end
      default: ;
    endcase
  end

  assign retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                  (state_d == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: each instruction's expected
// cycle-by-cycle control word is derived from its opcode class and wait counts.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready, branch_taken;
  logic        mem_req, mem_we, ir_write, pc_write, alu_src_b, reg_write;
  logic        halted, retire;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] model_instret;

  localparam int C_OP = 0, C_OPIMM = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4;
  localparam int C_LUI = 5, C_AUIPC = 6, C_JAL = 7, C_JALR = 8;

  logic [6:0] opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .state        (state),
    .halted       (halted),
    .retire       (retire),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [17:0] obs_vec();
    return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src_b, alu_op,
            reg_write, wb_sel, state, halted, retire};
  endfunction

  function automatic logic [17:0] mk(input logic mreq, input logic mwe, input logic irw,
                                     input logic pcw, input logic [1:0] psrc,
                                     input logic asb, input logic [1:0] aop,
                                     input logic rw, input logic [1:0] wbs,
                                     input logic [2:0] st, input logic hlt,
                                     input logic ret);
    return {mreq, mwe, irw, pcw, psrc, asb, aop, rw, wbs, st, hlt, ret};
  endfunction

  // Expected control word for one cycle of an instruction of class cls.
  function automatic logic [17:0] exp_vec(input int cls, input logic [2:0] st,
                                          input logic rdy, input logic bt,
                                          input logic [4:0] rd);
    logic [1:0] wbs;
    logic       rw;
    rw = (rd != 5'd0);
    case (cls)
      C_LOAD:         wbs = 2'd1;
      C_JAL, C_JALR:  wbs = 2'd2;
      C_LUI:          wbs = 2'd3;
      default:        wbs = 2'd0;
    endcase
    case (st)
      3'd1: return mk(1'b1, 1'b0, rdy, rdy, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0);
      3'd2: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0);
      3'd3: begin
        case (cls)
          C_OP:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b10, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b0);
          C_OPIMM: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b0);
          C_BR:    return mk(1'b0, 1'b0, 1'b0, bt, 2'd1, 1'b0, 2'b01, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b1);
          C_JAL:   return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'b00, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b0);
          C_JALR:  return mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'b00, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b0);
          default: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 1'b0, 2'd0, 3'd3,
                             1'b0, 1'b0);
        endcase
      end
      3'd4: return mk(1'b1, cls == C_STORE, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 3'd4,
                      1'b0, (cls == C_STORE) && rdy);
      default: return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, rw, wbs, 3'd5,
                         1'b0, 1'b1);
    endcase
  endfunction

  function automatic logic [31:0] make_inst(input int cls, input logic [4:0] rd);
    logic [31:0] w;
    w       = $urandom;
    w[6:0]  = opc[cls];
    w[11:7] = rd;
    return w;
  endfunction

  // Starts and ends one time unit after a rising edge with the DUT in FETCH.
  task automatic run_inst(input int cls, input logic [31:0] ins, input logic bt,
                          input int fw, input int mw);
    logic [2:0]  sts[$];
    logic        rdys[$];
    logic [17:0] e, o;
    for (int i = 0; i <= fw; i++) begin sts.push_back(3'd1); rdys.push_back(i == fw); end
    sts.push_back(3'd2); rdys.push_back(1'b0);
    sts.push_back(3'd3); rdys.push_back(1'b0);
    if (cls == C_LOAD || cls == C_STORE)
      for (int i = 0; i <= mw; i++) begin sts.push_back(3'd4); rdys.push_back(i == mw); end
    if (cls != C_BR && cls != C_STORE) begin sts.push_back(3'd5); rdys.push_back(1'b0); end
    for (int i = 0; i < sts.size(); i++) begin
      inst         = ins;
      mem_ready    = (sts[i] == 3'd1 || sts[i] == 3'd4) ? rdys[i] : 1'($urandom);
      branch_taken = (sts[i] == 3'd3) ? bt : 1'($urandom);
      #1;
      e = exp_vec(cls, sts[i], rdys[i], bt, ins[11:7]);
      o = obs_vec();
      total++;
      if (o !== e)
        $display("FAIL cycle inst=%h cls=%0d step=%0d: got %h expected %h",
                 ins, cls, i, o, e);
      else passed++;
      if (e[0]) model_instret = model_instret + 32'd1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 3'd1 || instret !== model_instret)
      $display("FAIL retire inst=%h: state=%0d instret=%h expected state=1 instret=%h",
               ins, state, instret, model_instret);
    else passed++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({obs_vec(), instret} !== 50'd0)
      $display("FAIL reset_outputs: got %h/%h expected all zero", obs_vec(), instret);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    model_instret = 32'd0;
    #1;
    @(posedge clk); #1;
    total++;
    if (obs_vec() !== 18'd0)
      $display("FAIL reset_idle: got %h expected 0", obs_vec());
    else passed++;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state !== 3'd1) $display("FAIL reset_fetch: state=%0d expected 1", state);
    else passed++;
  endtask

  task automatic test_reset();
    inst = 32'h0; branch_taken = 1'b0;
    do_reset();
  endtask

  task automatic test_addi();
    run_inst(C_OPIMM, 32'h00500093, 1'b0, 0, 0);
  endtask

  task automatic test_load_wait();
    run_inst(C_LOAD, 32'h0000a283, 1'b0, 0, 3);
  endtask

  task automatic test_branch();
    run_inst(C_BR, 32'h00000063, 1'b1, 0, 0);
    run_inst(C_BR, 32'h00000063, 1'b0, 0, 0);
  endtask

  task automatic test_x0_dest();
    run_inst(C_OPIMM, 32'h00100013, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int         cls;
      logic [4:0] rd;
      cls = $urandom_range(0, 8);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_inst(cls, make_inst(cls, rd), 1'($urandom), $urandom_range(0, 2),
               $urandom_range(0, 3));
    end
  endtask

  task automatic test_wrap();
    mem_ready = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    model_instret = 32'hFFFF_FFFF;
    total++;
    if (instret !== 32'hFFFF_FFFF) $display("FAIL preload: instret=%h expected ffffffff", instret);
    else passed++;
    @(posedge clk); #1;
    run_inst(C_OP, make_inst(C_OP, 5'd3), 1'b0, 0, 0);
  endtask

  task automatic test_halt();
    inst = 32'h0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    total++;
    if (state !== 3'd2) $display("FAIL halt_decode: state=%0d expected 2", state);
    else passed++;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      mem_ready = 1'($urandom); branch_taken = 1'($urandom);
      #1;
      total++;
      if (obs_vec() !== mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 3'd7,
                           1'b1, 1'b0) || instret !== model_instret)
        $display("FAIL halt_hold cycle %0d: got %h instret=%h", i, obs_vec(), instret);
      else passed++;
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    inst = 32'h0000a283; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (state !== 3'd4 || mem_req !== 1'b1)
      $display("FAIL mem_pending: state=%0d mem_req=%b expected 4/1", state, mem_req);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || state !== 3'd0 || instret !== 32'd0)
      $display("FAIL reset_mid_mem: mem_req=%b state=%0d instret=%h expected 0/0/0",
               mem_req, state, instret);
    else passed++;
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_instret = 32'd0;
    @(posedge clk); #1;
    total++;
    if (obs_vec() !== 18'd0) $display("FAIL post_reset_idle: got %h expected 0", obs_vec());
    else passed++;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state !== 3'd1 || ir_write !== 1'b0)
      $display("FAIL post_reset_fetch: state=%0d ir_write=%b expected 1/0", state, ir_write);
    else passed++;
    run_inst(C_STORE, make_inst(C_STORE, 5'd7), 1'b0, 1, 2);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_x0_dest();
    test_random();
    test_wrap();
    test_halt();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-003 SHALL have port inst, input, 32 bits: the instruction register contents, valid from DECODE onward.
REQ-004 SHALL have port mem_ready, input, 1 bit: the memory completion handshake for the current mem_req.
REQ-005 SHALL have port branch_taken, input, 1 bit: the branch comparison result from the datapath, valid in EXEC.
REQ-006 SHALL have port mem_req, output, 1 bit: the memory access request.
REQ-007 SHALL have port mem_we, output, 1 bit: the write qualifier for mem_req.
REQ-008 SHALL have port ir_write, output, 1 bit: the instruction register load enable.
REQ-009 SHALL have port pc_write, output, 1 bit: the PC load enable.
REQ-010 SHALL have port pc_src, output, 2 bits: the PC source select (0 = PC+4, 1 = PC+imm, 2 = ALU result).
REQ-011 SHALL have port alu_src_b, output, 1 bit: the ALU operand B select (0 = rs2, 1 = immediate).
REQ-012 SHALL have port alu_op, output, 2 bits: the ALU operation class (00 = add, 01 = compare, 10 = funct-decoded).
REQ-013 SHALL have port reg_write, output, 1 bit: the register file write enable.
REQ-014 SHALL have port wb_sel, output, 2 bits: the writeback source (0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate).
REQ-015 SHALL have port state, output, 3 bits: the current FSM state.
REQ-016 SHALL have port halted, output, 1 bit: the sticky illegal-opcode flag.
REQ-017 SHALL have port retire, output, 1 bit: a one-cycle pulse on instruction completion.
REQ-018 SHALL have port instret, output, 32 bits: the retired-instruction counter.

Function
REQ-019 SHALL encode the states as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=7; code 6 SHALL go to HALT.
REQ-020 SHALL go from IDLE to FETCH unconditionally after one cycle; every output SHALL be 0 in IDLE.
REQ-021 SHALL hold mem_req=1 and mem_we=0 in FETCH; when mem_ready=1 it SHALL assert ir_write=1, pc_write=1 and pc_src=0 in that cycle, then go to DECODE.
REQ-022 SHALL, in FETCH with mem_ready=0, remain in FETCH with ir_write=0 and pc_write=0; there is no timeout.
REQ-023 SHALL, in DECODE, go to EXEC when inst[6:0] is one of 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, and to HALT otherwise.
REQ-024 SHALL drive EXEC for each opcode class as follows:
  - OP: alu_src_b=0, alu_op=10, then WB.
  - OP-IMM: alu_src_b=1, alu_op=10, then WB.
  - LOAD/STORE: alu_src_b=1, alu_op=00, then MEM.
  - BRANCH: alu_src_b=0, alu_op=01, pc_src=1, pc_write=branch_taken, then FETCH (retire).
  - JAL: pc_src=1, pc_write=1, then WB.
  - JALR: alu_src_b=1, alu_op=00, pc_src=2, pc_write=1, then WB.
  - LUI/AUIPC: alu_src_b=1, alu_op=00, then WB.
REQ-025 SHALL hold mem_req=1 in MEM, with mem_we=1 only for STORE; it SHALL stay in MEM until mem_ready=1, then go to WB for LOAD or to FETCH (retire) for STORE.
REQ-026 SHALL, in WB, set wb_sel as follows: ALU for OP, OP-IMM and AUIPC; memory for LOAD; PC+4 for JAL and JALR; immediate for LUI. It SHALL assert reg_write=1 unless inst[11:7]=0, then go to FETCH (retire).
REQ-027 SHALL stay in HALT until reset, with halted=1 and all other control outputs 0.
REQ-028 SHALL pulse retire=1 for exactly one cycle on each transition into FETCH from EXEC, MEM or WB, never from IDLE; instret SHALL increment by 1 in that same cycle and wrap from 0xFFFFFFFF to 0.
REQ-029 SHALL take FETCH+DECODE+EXEC+WB = 4 cycles for OP, OP-IMM, LUI, AUIPC, JAL and JALR; 5 cycles for LOAD; 4 cycles for STORE; and 3 cycles for BRANCH, each with zero memory wait. Each memory wait cycle SHALL add 1 cycle.
REQ-030 SHALL hold unused select outputs at 0 in every state; outputs are decoded from the state register, plus mem_ready and branch_taken where stated.

Reset
REQ-031 SHALL, on rst=1, immediately and without waiting for clk, set state=IDLE, instret=0 and halted=0, and drive every output to 0.
REQ-032 SHALL, on reset during a pending FETCH or MEM, drop mem_req immediately; a mem_ready arriving during or after reset SHALL be ignored until the next FETCH.
REQ-033 SHALL, after rst falls, spend one cycle in IDLE and enter FETCH on the second rising edge.

Verification
REQ-034 SHALL pass this test: addi x1,x0,5 (0x00500093) with mem_ready tied 1 -> states 1,2,3,5,1; reg_write=1 and wb_sel=0 in WB; retire pulse; instret=1.
REQ-035 SHALL pass this test: lw with mem_ready low for 3 cycles in MEM -> mem_req held 4 cycles; WB wb_sel=1; total 8 cycles; instret +1.
REQ-036 SHALL pass this test: beq with branch_taken=1 and then 0 -> pc_write=1/pc_src=1 in EXEC only when taken; both cases return to FETCH after 3 cycles.
REQ-037 SHALL pass this test: inst=0x00000000 -> DECODE goes to HALT; halted=1 persists for 100 cycles; rst clears it and restarts at IDLE.
REQ-038 SHALL pass this test: addi x0,x0,1 -> reg_write stays 0 in WB; instret still increments.
REQ-039 SHALL pass this test: preload instret to 0xFFFFFFFF by force, then retire -> instret=0; and rst asserted mid-MEM -> mem_req=0 in the same cycle, state=0.
